full_adder_n_bit: RTL and testbench
===================================

# full_adder_n_bit

N-bit binary adder with carry-in, carry-out and signed-overflow detection, built from single-bit full-adder cells. The sum path is purely combinational and used directly in datapath arithmetic. A registered status stage provides clocked copies of the result, plus zero and overflow flags, for downstream pipeline consumers.

## Interface
Parameters:
- N, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  clock; all registered outputs update on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all registered outputs.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B, unsigned or two's complement.
- cin  input  1  carry-in into bit 0.
- in_valid  input  1  qualifies a, b and cin for capture by the status stage.
- y  output  N  combinational sum (a + b + cin) mod 2^N.
- cout  output  1  combinational carry-out of bit N-1.
- ovf  output  1  combinational signed overflow: (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]).
- y_q  output  N  registered y.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.
- zero_q  output  1  registered (y == 0).
- out_valid  output  1  registered in_valid.

## Operation
- The result satisfies {cout, y} = a + b + cin, exact over N+1 bits. There are no saturation or wrap exceptions.
- Bit cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = cin.
- y, cout and ovf depend only on a, b and cin:
  - They are independent of clk, reset_n and in_valid.
  - They have no state.
  - No X may propagate when all inputs are known.
- ovf is computed for every input and is meaningful only under a signed interpretation. cout is the unsigned overflow indicator.
- Status stage:
  - When in_valid=1 on a rising clk edge, the stage loads y_q, cout_q, ovf_q and zero_q from the current combinational values.
  - When in_valid=0, those four registers hold their previous values.
  - out_valid loads in_valid on every edge.
- N not a multiple of 4: the final lookahead group is partial and uses the same equations truncated to its width.

## Timing
- y, cout, ovf: zero-cycle latency. They must settle within one clock period from an input change to the output.
- Registered outputs have one-cycle latency. For inputs presented with in_valid=1 before edge k, the results are visible after edge k, and out_valid=1 after edge k.
- Reset values: y_q=0, cout_q=0, ovf_q=0, zero_q=0, out_valid=0.
- Asserting reset_n low at any time clears the registered outputs immediately, regardless of clk or in_valid.
- Combinational outputs keep tracking inputs during reset.
- Reset release: the first capture occurs on the first rising edge with reset_n=1 and in_valid=1.
- Back-to-back in_valid: one result per cycle, with no bubbles.

## Configuration
- FULLADDER_CLA_EN defined:
  - The carry chain uses 4-bit carry-lookahead groups, with group generate/propagate equations G = g3|p3g2|p3p2g1|p3p2p1g0 and P = p3p2p1p0.
  - Group carries ripple between groups.
- FULLADDER_CLA_EN undefined: pure ripple-carry chain of N full-adder cells.
- Functional results are bit-identical in both builds. Only depth and area differ. Both builds must pass the full test plan.

## Test plan
- a=8'hFF, b=8'h01, cin=0 -> y=8'h00, cout=1, ovf=0. With in_valid=1, the next cycle gives zero_q=1 and out_valid=1.
- a=8'h7F, b=8'h01, cin=0 -> y=8'h80, cout=0, ovf=1.
- a=8'h80, b=8'h80, cin=1 -> y=8'h01, cout=1, ovf=1, zero_q=0 after capture.
- a=8'h5A, b=8'hA5, cin=1 -> y=8'h00, cout=1, ovf=0. Applying the same operands with cin=0 gives y=8'hFF, cout=0.
- Hold and reset check:
  - Capture a=8'h12, b=8'h34, cin=0, which gives y_q=8'h46.
  - Drop in_valid and change the operands. y_q stays 8'h46 and out_valid=0.
  - Pulse reset_n low mid-cycle. All registered outputs read 0 immediately.
- Exhaustive sweep: all 2^17 combinations of (a, b, cin) at N=8 match a+b+cin. Repeat with FULLADDER_CLA_EN both defined and undefined, and at N=5.

Source files
------------

// File: rtl/full_adder_n_bit.sv
// full_adder_n_bit: N-bit adder (a + b + cin) with carry-out, signed overflow and a registered status stage.
// Ports: clk, reset_n (async active-low); a, b, cin, in_valid in;
//        y, cout, ovf combinational; y_q, cout_q, ovf_q, zero_q, out_valid registered.
// Define FULLADDER_CLA_EN for 4-bit carry-lookahead groups; otherwise the chain is pure ripple-carry.
module full_adder_n_bit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         in_valid,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] y_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         zero_q,
  output logic         out_valid
);
  logic [N-1:0] g, p;
  logic [N:0]   c;
`ifdef FULLADDER_CLA_EN
  logic gg, pp, cg;
`endif
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c = '0;
    c[0] = cin;
`ifdef FULLADDER_CLA_EN
    gg = 1'b0;
    pp = 1'b1;
    cg = cin;
    for (int i = 0; i < N; i++) begin
      // gg/pp are the group generate/propagate prefixes from the group's first bit,
      // so each carry is resolved from the group carry-in; the last group may be partial.
      if (i % 4 == 0) begin
        gg = 1'b0;
        pp = 1'b1;
        cg = c[i];
      end
      gg = g[i] | (p[i] & gg);
      pp = pp & p[i];
      c[i+1] = gg | (pp & cg);
    end
`else
    for (int i = 0; i < N; i++) c[i+1] = g[i] | (c[i] & p[i]);
`endif
  end
  assign y    = p ^ c[N-1:0];
  assign cout = c[N];
  assign ovf  = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q       <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q    <= y;
        cout_q <= cout;
        ovf_q  <= ovf;
        zero_q <= (y == '0);
      end
    end
  end
endmodule

// File: tb/tb_full_adder_n_bit.sv
// tb_full_adder_n_bit: directed and exhaustive checks of full_adder_n_bit at N=8 and N=5.
module tb_full_adder_n_bit;
  logic       clk = 1'b0, reset_n = 1'b0, cin = 1'b0, in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] y, y_q;
  logic       cout, ovf, cout_q, ovf_q, zero_q, out_valid;
  logic [4:0] y5, y5_q;
  logic       cout5, ovf5, cout5_q, ovf5_q, zero5_q, out5_valid;
  int vectors = 0, errors = 0;
  bit cmp_on = 1'b0;

  full_adder_n_bit #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .y(y), .cout(cout), .ovf(ovf), .y_q(y_q), .cout_q(cout_q), .ovf_q(ovf_q),
    .zero_q(zero_q), .out_valid(out_valid)
  );

  full_adder_n_bit #(.N(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .a(a[4:0]), .b(b[4:0]), .cin(cin), .in_valid(in_valid),
    .y(y5), .cout(cout5), .ovf(ovf5), .y_q(y5_q), .cout_q(cout5_q), .ovf_q(ovf5_q),
    .zero_q(zero5_q), .out_valid(out5_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h cin=%0b)", nm, act, exp, a, b, cin);
    end
  endtask

  // {ovf, cout, sum} from integer arithmetic on a w-bit slice of the operands
  function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] z, input logic ci);
    int m, h, ux, uz, s, sx, sz, ss;
    logic [7:0] sum;
    logic co, ov;
    m = (1 << w) - 1;
    h = 1 << (w - 1);
    ux = int'(x) & m;
    uz = int'(z) & m;
    s = ux + uz + int'(ci);
    sx = (ux >= h) ? ux - 2 * h : ux;
    sz = (uz >= h) ? uz - 2 * h : uz;
    ss = sx + sz + int'(ci);
    sum = 8'(s & m);
    co = ((s >> w) & 1) != 0;
    ov = (ss >= h) || (ss < -h);
    return {ov, co, sum};
  endfunction

  logic [9:0] r8, r5, m8, m5;
  logic [7:0] e_yq;
  logic [4:0] e5_yq;
  logic       e_cq, e_oq, e_zq, e5_cq, e5_oq, e5_zq, e_ov;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_yq = '0; e_cq = 0; e_oq = 0; e_zq = 0;
      e5_yq = '0; e5_cq = 0; e5_oq = 0; e5_zq = 0; e_ov = 0;
    end else begin
      e_ov = in_valid;
      if (in_valid) begin
        m8 = model(8, a, b, cin);
        m5 = model(5, a, b, cin);
        e_yq = m8[7:0]; e_cq = m8[8]; e_oq = m8[9]; e_zq = (m8[7:0] == 0);
        e5_yq = m5[4:0]; e5_cq = m5[8]; e5_oq = m5[9]; e5_zq = (m5[4:0] == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      r8 = model(8, a, b, cin);
      r5 = model(5, a, b, cin);
      chk("y", y, r8[7:0]);
      chk("cout", cout, r8[8]);
      chk("ovf", ovf, r8[9]);
      chk("y5", y5, r5[4:0]);
      chk("cout5", cout5, r5[8]);
      chk("ovf5", ovf5, r5[9]);
      chk("y_q", y_q, e_yq);
      chk("cout_q", cout_q, e_cq);
      chk("ovf_q", ovf_q, e_oq);
      chk("zero_q", zero_q, e_zq);
      chk("out_valid", out_valid, e_ov);
      chk("y5_q", y5_q, e5_yq);
      chk("cout5_q", cout5_q, e5_cq);
      chk("ovf5_q", ovf5_q, e5_oq);
      chk("zero5_q", zero5_q, e5_zq);
      chk("out5_valid", out5_valid, e_ov);
    end
  end

  task automatic apply(input logic [7:0] x, input logic [7:0] z, input logic ci, input logic v);
    @(posedge clk);
    #2;
    a = x; b = z; cin = ci; in_valid = v;
  endtask

  initial begin
    in_valid = 1'b1;
    a = 8'hFF; b = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("rst y_q", y_q, 8'h00);
    chk("rst cout_q", cout_q, 1'b0);
    chk("rst zero_q", zero_q, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst comb y", y, 8'h00);
    chk("rst comb cout", cout, 1'b1);
    #1 reset_n = 1'b1;
    cmp_on = 1'b1;
    apply(8'hFF, 8'h01, 1'b0, 1'b1);
    #1;
    chk("ff01 y", y, 8'h00); chk("ff01 cout", cout, 1'b1); chk("ff01 ovf", ovf, 1'b0);
    @(posedge clk); #1;
    chk("ff01 zero_q", zero_q, 1'b1); chk("ff01 out_valid", out_valid, 1'b1);
    chk("ff01 cout_q", cout_q, 1'b1);
    apply(8'h7F, 8'h01, 1'b0, 1'b1);
    #1;
    chk("7f01 y", y, 8'h80); chk("7f01 cout", cout, 1'b0); chk("7f01 ovf", ovf, 1'b1);
    apply(8'h80, 8'h80, 1'b1, 1'b1);
    #1;
    chk("8080 y", y, 8'h01); chk("8080 cout", cout, 1'b1); chk("8080 ovf", ovf, 1'b1);
    @(posedge clk); #1;
    chk("8080 zero_q", zero_q, 1'b0); chk("8080 y_q", y_q, 8'h01); chk("8080 ovf_q", ovf_q, 1'b1);
    apply(8'h5A, 8'hA5, 1'b1, 1'b1);
    #1;
    chk("5aa5c1 y", y, 8'h00); chk("5aa5c1 cout", cout, 1'b1); chk("5aa5c1 ovf", ovf, 1'b0);
    apply(8'h5A, 8'hA5, 1'b0, 1'b1);
    #1;
    chk("5aa5c0 y", y, 8'hFF); chk("5aa5c0 cout", cout, 1'b0);
    apply(8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("hold cap y_q", y_q, 8'h46);
    #1 a = 8'hAB; b = 8'hCD; cin = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold y_q", y_q, 8'h46); chk("hold out_valid", out_valid, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async y_q", y_q, 8'h00); chk("async out_valid", out_valid, 1'b0);
    chk("async zero_q", zero_q, 1'b0); chk("async y5_q", y5_q, 5'h00);
    in_valid = 1'b1;
    #1;
    chk("reset comb y", y, 8'h79);
    @(posedge clk); #1;
    chk("reset held y_q", y_q, 8'h00);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("release y_q", y_q, 8'h79); chk("release out_valid", out_valid, 1'b1);
    apply(8'h01, 8'h02, 1'b0, 1'b1);
    apply(8'hF0, 8'h0F, 1'b1, 1'b1);
    apply(8'h40, 8'h40, 1'b0, 1'b1);
    apply(8'hC0, 8'hBF, 1'b0, 1'b1);
    apply(8'h13, 8'h0D, 1'b0, 1'b1);
    apply(8'hFF, 8'hFF, 1'b1, 1'b1);
    apply(8'h00, 8'h00, 1'b0, 1'b0);
    apply(8'h0F, 8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("b2b last y_q", y_q, 8'h10); chk("b2b last out_valid", out_valid, 1'b1);
    cmp_on = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        for (int k = 0; k < 2; k++) begin
          a = 8'(i); b = 8'(j); cin = k[0];
          #1;
          r8 = model(8, a, b, cin);
          chk("sweep8 y", {cout, y}, r8[8:0]);
          chk("sweep8 ovf", ovf, r8[9]);
          if (i < 32 && j < 32) begin
            r5 = model(5, a, b, cin);
            chk("sweep5 y", {cout5, y5}, {r5[8], r5[4:0]});
            chk("sweep5 ovf", ovf5, r5[9]);
          end
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
